sel_sequencer: RTL and testbench

SEL_SEQUENCER -- requirements
Module: sel_sequencer

---
 rtl/sel_seq_pkg.sv | 12 +
 rtl/sel_fifo.sv | 60 ++++++
 rtl/sel_sequencer.sv | 117 +++++++++++
 tb/tb_sel_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sel_seq_pkg.sv
// Shared types and defaults for the select-line sequencer and its code FIFO.
package sel_seq_pkg;

  localparam int DEPTH_DEFAULT   = 4;
  localparam int DWELL_W_DEFAULT = 4;

  typedef enum logic {
    IDLE,
    HOLD
  } seq_state_t;

endpackage

// File: rtl/sel_fifo.sv
// Small code FIFO feeding the sequencer; DEPTH must be a power of two so the
// pointers wrap naturally.
module sel_fifo
  import sel_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [1:0]             push_data,
  input  logic                   pop,
  output logic [1:0]             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // A refused push (full) never counts, even when a pop frees a slot that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sel_sequencer.sv
// Dispatches queued 2-bit select codes onto A1/A0, holding each for max(dwell,1)
// cycles. Define SEL_SEQ_OVF_EN to add the sticky ovf (refused push) output.
module sel_sequencer
  import sel_seq_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int DWELL_W = DWELL_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [1:0]             in_code,
  output logic                   in_ready,
  input  logic [DWELL_W-1:0]     dwell,
  output logic                   A1,
  output logic                   A0,
  output logic                   sel_valid,
  output logic [$clog2(DEPTH):0] count
`ifdef SEL_SEQ_OVF_EN
  ,
  output logic                   ovf
`endif
);

  seq_state_t         state, next_state;
  logic [DWELL_W-1:0] dwell_cnt, next_cnt;
  logic [DWELL_W-1:0] dwell_load;
  logic [1:0]         code_q, next_code;
  logic               next_valid;
  logic               pop;
  logic               full;
  logic               empty;
  logic [1:0]         head;

  sel_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (in_valid),
    .push_data(in_code),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  assign in_ready   = !full;
  assign dwell_load = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign {A1, A0}   = code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dwell_cnt <= '0;
      code_q    <= 2'b00;
      sel_valid <= 1'b0;
    end else begin
      state     <= next_state;
      dwell_cnt <= next_cnt;
      code_q    <= next_code;
      sel_valid <= next_valid;
    end
  end

  // The last hold cycle reloads straight from the FIFO so codes run back-to-back.
  always_comb begin
    next_state = state;
    next_cnt   = dwell_cnt;
    next_code  = code_q;
    next_valid = sel_valid;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_code  = head;
          next_cnt   = dwell_load;
          next_valid = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (dwell_cnt == DWELL_W'(1)) begin
          if (!empty) begin
            pop        = 1'b1;
            next_code  = head;
            next_cnt   = dwell_load;
            next_valid = 1'b1;
          end else begin
            next_cnt   = '0;
            next_valid = 1'b0;
            next_state = IDLE;
          end
        end else begin
          next_cnt = dwell_cnt - DWELL_W'(1);
        end
      end
      default: begin
        next_state = IDLE;
        next_valid = 1'b0;
      end
    endcase
  end

`ifdef SEL_SEQ_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid && !in_ready) begin
      ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sel_sequencer.sv
// Scoreboard bench for sel_sequencer: accepted pushes queue an expected
// {code, hold length}; a negedge monitor checks every dispatched cycle.
module tb_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_code = 2'b00;
  logic       in_ready;
  logic [3:0] dwell = 4'd1;
  logic       A1;
  logic       A0;
  logic       sel_valid;
  logic [2:0] count;
`ifdef SEL_SEQ_OVF_EN
  logic       ovf;
`endif

  typedef struct {
    logic [1:0] code;
    int         hold;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       push_e;
  exp_t       mon_e;
  int         total = 0;
  int         bad = 0;
  int         accepted = 0;
  int         remaining = 0;
  int         run = 0;
  int         last_run = 0;
  logic [1:0] cur_code = 2'b00;
  logic [3:0] dec;

  sel_sequencer #(
    .DEPTH  (4),
    .DWELL_W(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_code  (in_code),
    .in_ready (in_ready),
    .dwell    (dwell),
    .A1       (A1),
    .A0       (A0),
    .sel_valid(sel_valid),
    .count    (count)
`ifdef SEL_SEQ_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  // 2-to-4 decoder driven by the select lines
  assign dec = 4'b0001 << {A1, A0};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] code);
    in_valid = 1'b1;
    in_code  = code;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!sel_valid && count == 3'd0 && exp_q.size() == 0 && remaining == 0) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("drain_timeout", {31'd0, done}, 32'd1);
    tick();
  endtask

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      push_e.code = in_code;
      push_e.hold = (dwell == 4'd0) ? 1 : int'(dwell);
      exp_q.push_back(push_e);
      accepted++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      remaining = 0;
      run       = 0;
      cur_code  = 2'b00;
    end else if (sel_valid) begin
      run++;
      if (remaining == 0) begin
        checkOutput("dispatch_avail", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          mon_e     = exp_q.pop_front();
          cur_code  = mon_e.code;
          remaining = mon_e.hold;
        end
        checkOutput("dispatch_code", {30'd0, A1, A0}, {30'd0, cur_code});
      end else begin
        checkOutput("hold_code", {30'd0, A1, A0}, {30'd0, cur_code});
      end
      checkOutput("decoder_onehot", {28'd0, dec}, 32'd1 << cur_code);
      if (remaining > 0) remaining--;
    end else begin
      if (run != 0) last_run = run;
      run = 0;
      if (remaining != 0) begin
        checkOutput("early_drop", remaining, 0);
        remaining = 0;
      end
      checkOutput("idle_retain", {30'd0, A1, A0}, {30'd0, cur_code});
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int exp_cnt[4];
    exp_cnt = '{1, 1, 2, 2};

    tick();
    tick();
    checkOutput("rst_count", {29'd0, count}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_sel_valid", {31'd0, sel_valid}, 32'd0);
    checkOutput("rst_sel", {30'd0, A1, A0}, 32'd0);
`ifdef SEL_SEQ_OVF_EN
    checkOutput("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst_n = 1'b1;

    $display("[TB] four codes, dwell=1");
    dwell = 4'd1;
    applyStimulus(2'b00);
    applyStimulus(2'b01);
    applyStimulus(2'b10);
    applyStimulus(2'b11);
    waitDrain(50);
    checkOutput("b2b_run_len", last_run, 4);

    $display("[TB] latency and dwell=3");
    dwell    = 4'd3;
    in_valid = 1'b1;
    in_code  = 2'b10;
    tick();
    in_valid = 1'b0;
    checkOutput("lat_edge_k_valid", {31'd0, sel_valid}, 32'd0);
    checkOutput("lat_edge_k_count", {29'd0, count}, 32'd1);
    tick();
    checkOutput("lat_edge_k1_valid", {31'd0, sel_valid}, 32'd1);
    checkOutput("lat_edge_k1_sel", {30'd0, A1, A0}, 32'd2);
    checkOutput("lat_edge_k1_count", {29'd0, count}, 32'd0);
    waitDrain(50);
    checkOutput("dwell3_run_len", last_run, 3);
    checkOutput("dwell3_retain", {30'd0, A1, A0}, 32'd2);

    $display("[TB] dwell=0 acts as 1");
    dwell = 4'd0;
    applyStimulus(2'b11);
    applyStimulus(2'b01);
    waitDrain(50);
    checkOutput("dwell0_run_len", last_run, 2);

    $display("[TB] dwell change during hold");
    dwell = 4'd3;
    applyStimulus(2'b01);
    tick();
    dwell = 4'd9;
    waitDrain(50);
    checkOutput("dwell_change_run_len", last_run, 3);

    $display("[TB] simultaneous push and pop at count=2");
    dwell = 4'd2;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_code  = 2'(3 - i);
      tick();
      checkOutput("pushpop_count", {29'd0, count}, exp_cnt[i]);
    end
    in_valid = 1'b0;
    waitDrain(50);

    $display("[TB] overflow with dwell=15");
    dwell    = 4'd15;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_code  = 2'(i);
      tick();
    end
    checkOutput("full_accepted", accepted, 5);
    checkOutput("full_count", {29'd0, count}, 32'd4);
    checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
`ifdef SEL_SEQ_OVF_EN
    checkOutput("full_ovf", {31'd0, ovf}, 32'd1);
`endif
    for (int i = 6; i < 20; i++) begin
      in_code = 2'(i);
      tick();
    end
    in_valid = 1'b0;
    waitDrain(400);

    $display("[TB] reset mid-hold with codes queued");
    dwell = 4'd5;
    applyStimulus(2'b01);
    applyStimulus(2'b10);
    applyStimulus(2'b11);
    applyStimulus(2'b01);
    checkOutput("pre_rst_count", {29'd0, count}, 32'd3);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_count", {29'd0, count}, 32'd0);
    checkOutput("midrst_sel_valid", {31'd0, sel_valid}, 32'd0);
    checkOutput("midrst_sel", {30'd0, A1, A0}, 32'd0);
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    checkOutput("postrst_sel_valid", {31'd0, sel_valid}, 32'd0);
    checkOutput("postrst_count", {29'd0, count}, 32'd0);
`ifdef SEL_SEQ_OVF_EN
    checkOutput("postrst_ovf", {31'd0, ovf}, 32'd0);
`endif

    dwell = 4'd1;
    applyStimulus(2'b10);
    waitDrain(50);
    checkOutput("final_run_len", last_run, 1);
    checkOutput("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
